cv32e40x_bch_resolve: RTL and testbench

Branch resolution unit: consumes the static branch prediction and branch target produced in ID, tracks the branch through EX until the ALU comparator decides it, and on a mispredict issues a redirect request to IF together with an ID flush. It is the checking end of the ID-stage predict/target path and sits between the ID/EX boundary and the IF redirect/controller interface.

---
 rtl/cv32e40x_pkg.sv | 19 +
 rtl/cv32e40x_bch_stats.sv | 36 +++
 rtl/cv32e40x_bch_resolve.sv | 97 +++++++++
 tb/tb_cv32e40x_bch_resolve.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40x_pkg.sv
// Shared types and constants for the branch resolution slice.
package cv32e40x_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    REDIRECT = 2'd2
  } bch_res_state_e;

  localparam logic [31:0] BCH_FT_INC_RVC = 32'd2;
  localparam logic [31:0] BCH_FT_INC_RV  = 32'd4;

  // Address of the instruction following the branch; wraps modulo 2^32.
  function automatic logic [31:0] bch_fallthrough(input logic [31:0] pc,
                                                  input logic        is_compressed);
    return pc + (is_compressed ? BCH_FT_INC_RVC : BCH_FT_INC_RV);
  endfunction

endpackage

// File: rtl/cv32e40x_bch_stats.sv
// Two saturating 32-bit event counters: resolved branches and mispredicts.
module cv32e40x_bch_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        inc_mispredict,
  output logic [31:0] bch_count,
  output logic [31:0] mispredict_count
);

  logic [1:0]       inc_vec;
  logic [1:0][31:0] count_vec;

  assign inc_vec = {inc_mispredict, inc};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [31:0] count_reg;

      // Holds at all-ones instead of wrapping back to zero.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          count_reg <= '0;
        end else if (inc_vec[gi] && (count_reg != 32'hFFFF_FFFF)) begin
          count_reg <= count_reg + 32'd1;
        end
      end

      assign count_vec[gi] = count_reg;
    end
  endgenerate

  assign bch_count        = count_vec[0];
  assign mispredict_count = count_vec[1];

endmodule

// File: rtl/cv32e40x_bch_resolve.sv
// Branch resolution: checks the ID static prediction against the EX outcome and
// requests an IF redirect on mispredict. Statistics counters need CV32E40X_BCH_STATS_EN.
module cv32e40x_bch_resolve
  import cv32e40x_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid_i,
  output logic        ex_ready_o,
  input  logic        bch_in_id_i,
  input  logic        bch_prediction_id_i,
  input  logic [31:0] bch_target_id_i,
  input  logic [31:0] pc_id_i,
  input  logic        is_compressed_id_i,
  input  logic        bch_decision_valid_i,
  input  logic        bch_decision_i,
  input  logic        kill_ex_i,
  output logic        redirect_valid_o,
  input  logic        redirect_ready_i,
  output logic [31:0] redirect_pc_o,
  output logic        flush_id_o,
  output logic [31:0] bch_count_o,
  output logic [31:0] mispredict_count_o
);

  bch_res_state_e state_q;
  logic           pred_q;
  logic [31:0]    target_q;
  logic [31:0]    fallthrough_q;
  logic [31:0]    redirect_pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pred_q        <= 1'b0;
      target_q      <= '0;
      fallthrough_q <= '0;
      redirect_pc_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (id_valid_i && bch_in_id_i && !kill_ex_i) begin
            pred_q        <= bch_prediction_id_i;
            target_q      <= bch_target_id_i;
            fallthrough_q <= bch_fallthrough(pc_id_i, is_compressed_id_i);
            state_q       <= WAIT;
          end
        end
        WAIT: begin
          if (kill_ex_i) begin
            state_q <= IDLE;
          end else if (bch_decision_valid_i) begin
            if (bch_decision_i != pred_q) begin
              redirect_pc_q <= bch_decision_i ? target_q : fallthrough_q;
              state_q       <= REDIRECT;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        REDIRECT: begin
          // A controller kill supersedes our redirect, so it is simply dropped.
          if (kill_ex_i || redirect_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ex_ready_o       = (state_q == IDLE);
  assign redirect_valid_o = (state_q == REDIRECT);
  assign redirect_pc_o    = redirect_pc_q;
  assign flush_id_o       = redirect_valid_o && redirect_ready_i && !kill_ex_i;

`ifdef CV32E40X_BCH_STATS_EN
  logic decide;
  logic mispredict;

  assign decide     = (state_q == WAIT) && bch_decision_valid_i && !kill_ex_i;
  assign mispredict = decide && (bch_decision_i != pred_q);

  cv32e40x_bch_stats u_stats (
    .clk              (clk),
    .rst_n            (rst_n),
    .inc              (decide),
    .inc_mispredict   (mispredict),
    .bch_count        (bch_count_o),
    .mispredict_count (mispredict_count_o)
  );
`else
  assign bch_count_o        = '0;
  assign mispredict_count_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40x_bch_resolve.sv
// Directed bench for cv32e40x_bch_resolve; expected redirect PCs go through a queue.
module tb_cv32e40x_bch_resolve;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid_i;
  logic        ex_ready_o;
  logic        bch_in_id_i;
  logic        bch_prediction_id_i;
  logic [31:0] bch_target_id_i;
  logic [31:0] pc_id_i;
  logic        is_compressed_id_i;
  logic        bch_decision_valid_i;
  logic        bch_decision_i;
  logic        kill_ex_i;
  logic        redirect_valid_o;
  logic        redirect_ready_i;
  logic [31:0] redirect_pc_o;
  logic        flush_id_o;
  logic [31:0] bch_count_o;
  logic [31:0] mispredict_count_o;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] bch_exp = '0;
  logic [31:0] mis_exp = '0;

  cv32e40x_bch_resolve dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .id_valid_i           (id_valid_i),
    .ex_ready_o           (ex_ready_o),
    .bch_in_id_i          (bch_in_id_i),
    .bch_prediction_id_i  (bch_prediction_id_i),
    .bch_target_id_i      (bch_target_id_i),
    .pc_id_i              (pc_id_i),
    .is_compressed_id_i   (is_compressed_id_i),
    .bch_decision_valid_i (bch_decision_valid_i),
    .bch_decision_i       (bch_decision_i),
    .kill_ex_i            (kill_ex_i),
    .redirect_valid_o     (redirect_valid_o),
    .redirect_ready_i     (redirect_ready_i),
    .redirect_pc_o        (redirect_pc_o),
    .flush_id_o           (flush_id_o),
    .bch_count_o          (bch_count_o),
    .mispredict_count_o   (mispredict_count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_counts(input string tag);
`ifdef CV32E40X_BCH_STATS_EN
    chk({tag, "_bch_count"}, bch_count_o, bch_exp);
    chk({tag, "_mis_count"}, mispredict_count_o, mis_exp);
`else
    chk({tag, "_bch_count"}, bch_count_o, 32'd0);
    chk({tag, "_mis_count"}, mispredict_count_o, 32'd0);
`endif
  endtask

  // Capture one branch, then present its decision (optionally with a kill).
  task automatic branch(input logic pred, input logic [31:0] tgt, input logic [31:0] pc,
                        input logic rvc, input logic dec, input logic kill);
    id_valid_i = 1'b1; bch_in_id_i = 1'b1; bch_prediction_id_i = pred;
    bch_target_id_i = tgt; pc_id_i = pc; is_compressed_id_i = rvc;
    tick();
    id_valid_i = 1'b0; bch_in_id_i = 1'b0;
    chk("captured_busy", {31'd0, ex_ready_o}, 32'd0);
    bch_decision_valid_i = 1'b1; bch_decision_i = dec; kill_ex_i = kill;
    if (!kill) begin
      bch_exp++;
      if (dec != pred) begin
        mis_exp++;
        exp_q.push_back(dec ? tgt : pc + (rvc ? 32'd2 : 32'd4));
      end
    end
    tick();
    bch_decision_valid_i = 1'b0; kill_ex_i = 1'b0;
  endtask

  // Hold off the redirect for 'stall' cycles, then accept it.
  task automatic take_redirect(input int stall);
    logic [31:0] exp_pc;
    if (exp_q.size() == 0) begin
      exp_pc = 32'hDEAD_BEEF;
      chk("scoreboard_empty", 32'd1, 32'd0 + exp_q.size());
    end else begin
      exp_pc = exp_q.pop_front();
    end
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", {31'd0, redirect_valid_o}, 32'd1);
      chk("stall_pc", redirect_pc_o, exp_pc);
      chk("stall_no_flush", {31'd0, flush_id_o}, 32'd0);
      tick();
    end
    chk("redirect_valid", {31'd0, redirect_valid_o}, 32'd1);
    chk("redirect_pc", redirect_pc_o, exp_pc);
    redirect_ready_i = 1'b1;
    #1;
    chk("flush_on_accept", {31'd0, flush_id_o}, 32'd1);
    tick();
    redirect_ready_i = 1'b0;
    #1;
    chk("flush_pulse_end", {31'd0, flush_id_o}, 32'd0);
    chk("idle_after_accept", {31'd0, ex_ready_o}, 32'd1);
    chk("redirect_dropped", {31'd0, redirect_valid_o}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ex_ready"}, {31'd0, ex_ready_o}, 32'd1);
    chk({tag, "_redirect_valid"}, {31'd0, redirect_valid_o}, 32'd0);
    chk({tag, "_redirect_pc"}, redirect_pc_o, 32'd0);
    chk({tag, "_flush"}, {31'd0, flush_id_o}, 32'd0);
    chk_counts(tag);
  endtask

  initial begin
    rst_n = 1'b0; id_valid_i = 1'b0; bch_in_id_i = 1'b0; bch_prediction_id_i = 1'b0;
    bch_target_id_i = '0; pc_id_i = '0; is_compressed_id_i = 1'b0;
    bch_decision_valid_i = 1'b0; bch_decision_i = 1'b0; kill_ex_i = 1'b0;
    redirect_ready_i = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_reset_outputs("reset");

    // Predicted not taken, taken in EX: redirect to target.
    branch(1'b0, 32'h0000_0080, 32'h0000_0100, 1'b0, 1'b1, 1'b0);
    chk_counts("nt_taken");
    take_redirect(0);

    // Predicted taken, not taken in EX on a compressed branch: redirect to pc+2.
    branch(1'b1, 32'h0000_0040, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
    take_redirect(0);
    chk_counts("t_nottaken");

    // Correct prediction: ready again the cycle after the decision.
    branch(1'b1, 32'h0000_0200, 32'h0000_0300, 1'b0, 1'b1, 1'b0);
    chk("correct_ready", {31'd0, ex_ready_o}, 32'd1);
    chk("correct_no_redirect", {31'd0, redirect_valid_o}, 32'd0);
    chk_counts("correct");

    // Backpressure: redirect held for three cycles.
    branch(1'b0, 32'h0000_1000, 32'h0000_2000, 1'b0, 1'b1, 1'b0);
    take_redirect(3);
    chk_counts("backpressure");

    // Kill during decision: nothing counted, no redirect.
    branch(1'b0, 32'h0000_3000, 32'h0000_4000, 1'b0, 1'b1, 1'b1);
    chk("kill_wait_ready", {31'd0, ex_ready_o}, 32'd1);
    chk("kill_wait_no_redirect", {31'd0, redirect_valid_o}, 32'd0);
    chk_counts("kill_wait");

    // Kill while redirecting, same cycle as accept: no flush, redirect dropped.
    branch(1'b1, 32'h0000_5000, 32'h0000_6000, 1'b0, 1'b0, 1'b0);
    chk("kill_redir_valid", {31'd0, redirect_valid_o}, 32'd1);
    chk("kill_redir_pc", redirect_pc_o, exp_q.pop_front());
    redirect_ready_i = 1'b1; kill_ex_i = 1'b1;
    #1;
    chk("kill_redir_no_flush", {31'd0, flush_id_o}, 32'd0);
    tick();
    redirect_ready_i = 1'b0; kill_ex_i = 1'b0;
    chk("kill_redir_idle", {31'd0, ex_ready_o}, 32'd1);
    chk("kill_redir_dropped", {31'd0, redirect_valid_o}, 32'd0);

    // Kill beats capture in IDLE.
    id_valid_i = 1'b1; bch_in_id_i = 1'b1; kill_ex_i = 1'b1;
    tick();
    id_valid_i = 1'b0; bch_in_id_i = 1'b0; kill_ex_i = 1'b0;
    chk("kill_capture_idle", {31'd0, ex_ready_o}, 32'd1);

    // Decision ignored while IDLE.
    bch_decision_valid_i = 1'b1; bch_decision_i = 1'b1;
    tick();
    bch_decision_valid_i = 1'b0;
    chk("idle_decision_no_redirect", {31'd0, redirect_valid_o}, 32'd0);
    chk_counts("idle_decision");

    // Fall-through wraps past the top of the address space.
    branch(1'b1, 32'h0000_0010, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    take_redirect(1);
    chk_counts("wrap");

    // Reset in the middle of a pending redirect.
    branch(1'b0, 32'hCAFE_0000, 32'h0000_7000, 1'b0, 1'b1, 1'b0);
    chk("pre_reset_valid", {31'd0, redirect_valid_o}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    bch_exp = '0; mis_exp = '0;
    chk_reset_outputs("redir_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
